// File: rtl/emu_pkg.sv
// Shared definitions for the emulator host-side Wishbone master.
package emu_pkg;

  localparam int unsigned WB_DW   = 32;
  localparam int unsigned WB_AW   = 32;
  localparam int unsigned WB_SELW = 4;

  localparam logic [WB_DW-1:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBus  = 2'd1,
    StResp = 2'd2
  } state_e;

endpackage

// File: rtl/emu_wb_timeout.sv
// Saturating bus-wait counter with synchronous clear, enable and terminal-count flag.
module emu_wb_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] CntTc  = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The count equals the number of stb cycles already spent, so this marks the last one.
  assign tc_o = (cnt_q == CntTc);

endmodule

// File: rtl/emu_wb_host_master.sv
// Host-side Classic Wishbone master: one command in, one single-beat bus cycle, one response out.
module emu_wb_host_master
  import emu_pkg::*;
#(
  parameter int unsigned      TIMEOUT_CYCLES = 255,
  parameter logic [WB_DW-1:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_ni,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic               cmd_we_i,
  input  logic [WB_AW-1:0]   cmd_adr_i,
  input  logic [WB_DW-1:0]   cmd_dat_i,
  input  logic [WB_SELW-1:0] cmd_sel_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [WB_DW-1:0]   rsp_dat_o,
  output logic               rsp_err_o,
  output logic               wbs_cyc_o,
  output logic               wbs_stb_o,
  output logic               wbs_we_o,
  output logic [WB_SELW-1:0] wbs_sel_o,
  output logic [WB_AW-1:0]   wbs_adr_o,
  output logic [WB_DW-1:0]   wbs_dat_o,
  input  logic [WB_DW-1:0]   wbs_dat_i,
  input  logic               wbs_ack_i,
  output logic               busy_o
);

  state_e             state_q, state_d;
  logic               cyc_q, cyc_d;
  logic               we_q, we_d;
  logic [WB_AW-1:0]   adr_q, adr_d;
  logic [WB_DW-1:0]   dat_q, dat_d;
  logic [WB_SELW-1:0] sel_q, sel_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [WB_DW-1:0]   rsp_dat_q, rsp_dat_d;
  logic               rsp_err_q, rsp_err_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               cnt_clr, cnt_en, cnt_tc;

  emu_wb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i (wb_clk_i),
    .rst_ni(wb_rst_ni),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .tc_o  (cnt_tc)
  );

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid_i && cmd_ready_q) begin
          we_d    = cmd_we_i;
          adr_d   = cmd_adr_i;
          dat_d   = cmd_dat_i;
          sel_d   = cmd_sel_i;
          cyc_d   = 1'b1;
          cnt_clr = 1'b1;
          state_d = StBus;
        end
      end
      StBus: begin
        // Ack is checked first so an ack on the terminal cycle still completes cleanly.
        if (wbs_ack_i) begin
          cyc_d       = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_dat_d   = we_q ? '0 : wbs_dat_i;
          rsp_valid_d = 1'b1;
          state_d     = StResp;
        end else if (cnt_tc) begin
          cyc_d       = 1'b0;
          rsp_err_d   = 1'b1;
          rsp_dat_d   = we_q ? '0 : ERR_DATA;
          rsp_valid_d = 1'b1;
          state_d     = StResp;
        end else begin
          cnt_en = 1'b1;
        end
      end
      StResp: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: begin
        cyc_d       = 1'b0;
        rsp_valid_d = 1'b0;
        state_d     = StIdle;
      end
    endcase

    // Registered so that ready stays low while reset is asserted and has no input path.
    cmd_ready_d = (state_d == StIdle);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q     <= StIdle;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
      cmd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_dat_o   = rsp_dat_q;
  assign rsp_err_o   = rsp_err_q;
  assign wbs_cyc_o   = cyc_q;
  assign wbs_stb_o   = cyc_q;
  assign wbs_we_o    = we_q;
  assign wbs_sel_o   = sel_q;
  assign wbs_adr_o   = adr_q;
  assign wbs_dat_o   = dat_q;
  assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_emu_wb_host_master.sv
// Directed bench for emu_wb_host_master with TIMEOUT_CYCLES=8; inputs change and outputs are
// sampled on the falling edge.
module tb_emu_wb_host_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_dat;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_o, dat_i;
  logic        ack, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  emu_wb_host_master #(
    .TIMEOUT_CYCLES(8),
    .ERR_DATA      (32'hDEAD_BEEF)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_ni  (rst_n),
    .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready),
    .cmd_we_i   (cmd_we),
    .cmd_adr_i  (cmd_adr),
    .cmd_dat_i  (cmd_dat),
    .cmd_sel_i  (cmd_sel),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_dat_o  (rsp_dat),
    .rsp_err_o  (rsp_err),
    .wbs_cyc_o  (cyc),
    .wbs_stb_o  (stb),
    .wbs_we_o   (we),
    .wbs_sel_o  (sel),
    .wbs_adr_o  (adr),
    .wbs_dat_o  (dat_o),
    .wbs_dat_i  (dat_i),
    .wbs_ack_i  (ack),
    .busy_o     (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents a command at a falling edge; returns at the falling edge of the first stb cycle.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    cmd_valid = 1'b1;
    cmd_we    = w;
    cmd_adr   = a;
    cmd_dat   = d;
    cmd_sel   = s;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic rsp_handshake();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_after_hs", {31'd0, rsp_valid}, 32'd0);
    chk("cmd_ready_after_hs", {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_adr   = '0;
    cmd_dat   = '0;
    cmd_sel   = '0;
    rsp_ready = 1'b0;
    dat_i     = '0;
    ack       = 1'b0;

    // Reset state
    #12;
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_cyc", {31'd0, cyc}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_adr", adr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // Read with ack in the first stb cycle
    issue(1'b0, 32'h3000_0004, 32'h1111_2222, 4'hF);
    chk("rd1_cyc", {31'd0, cyc}, 32'd1);
    chk("rd1_stb", {31'd0, stb}, 32'd1);
    chk("rd1_adr", adr, 32'h3000_0004);
    chk("rd1_we", {31'd0, we}, 32'd0);
    chk("rd1_dat_o", dat_o, 32'h1111_2222);
    chk("rd1_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rd1_busy", {31'd0, busy}, 32'd1);
    chk("rd1_rsp_valid_early", {31'd0, rsp_valid}, 32'd0);
    ack   = 1'b1;
    dat_i = 32'h1234_5678;
    @(negedge clk);
    ack   = 1'b0;
    dat_i = 32'h0;
    chk("rd1_cyc_drop", {31'd0, cyc}, 32'd0);
    chk("rd1_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("rd1_rsp_dat", rsp_dat, 32'h1234_5678);
    chk("rd1_rsp_err", {31'd0, rsp_err}, 32'd0);
    rsp_handshake();

    // Write, ack in the sixth stb cycle
    issue(1'b1, 32'h3000_0000, 32'hA5A5_A5A5, 4'b0011);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("wr_cyc_%0d", i), {31'd0, cyc}, 32'd1);
      chk($sformatf("wr_bus_%0d", i), {we, sel, adr[26:0]}, {1'b1, 4'b0011, 27'h000_0000});
      chk($sformatf("wr_dat_%0d", i), dat_o, 32'hA5A5_A5A5);
      if (i == 5) begin
        ack   = 1'b1;
        dat_i = 32'hFFFF_FFFF;
      end
      @(negedge clk);
    end
    ack = 1'b0;
    chk("wr_cyc_drop", {31'd0, cyc}, 32'd0);
    chk("wr_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("wr_rsp_dat", rsp_dat, 32'h0);
    chk("wr_rsp_err", {31'd0, rsp_err}, 32'd0);
    rsp_handshake();

    // Read that times out after 8 stb cycles
    issue(1'b0, 32'h3000_0008, 32'h0, 4'hF);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("to_cyc_%0d", i), {31'd0, cyc}, 32'd1);
      @(negedge clk);
    end
    chk("to_cyc_drop", {31'd0, cyc}, 32'd0);
    chk("to_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("to_rsp_err", {31'd0, rsp_err}, 32'd1);
    chk("to_rsp_dat", rsp_dat, 32'hDEAD_BEEF);
    @(negedge clk);
    @(negedge clk);
    ack   = 1'b1;
    dat_i = 32'h5555_5555;
    @(negedge clk);
    ack = 1'b0;
    chk("late_ack_cyc", {31'd0, cyc}, 32'd0);
    chk("late_ack_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("late_ack_rsp_dat", rsp_dat, 32'hDEAD_BEEF);
    chk("late_ack_rsp_err", {31'd0, rsp_err}, 32'd1);
    rsp_handshake();

    // Stray ack in idle
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("stray_ack_busy", {31'd0, busy}, 32'd0);
    chk("stray_ack_cyc", {31'd0, cyc}, 32'd0);
    chk("stray_ack_rsp_valid", {31'd0, rsp_valid}, 32'd0);

    // Ack on the terminal timeout cycle
    issue(1'b0, 32'h3000_000C, 32'h0, 4'hF);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("term_cyc_%0d", i), {31'd0, cyc}, 32'd1);
      if (i == 7) begin
        ack   = 1'b1;
        dat_i = 32'hCAFE_F00D;
      end
      @(negedge clk);
    end
    ack = 1'b0;
    chk("term_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("term_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("term_rsp_dat", rsp_dat, 32'hCAFE_F00D);

    // Backpressure: response held 10 cycles while a new command waits
    cmd_valid = 1'b1;
    cmd_we    = 1'b1;
    cmd_adr   = 32'h3000_0010;
    cmd_dat   = 32'h0BAD_CAFE;
    cmd_sel   = 4'hC;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("bp_hold_%0d", i), {rsp_valid, rsp_err, cmd_ready, cyc}, 4'b1000);
      chk($sformatf("bp_dat_%0d", i), rsp_dat, 32'hCAFE_F00D);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp_after_hs_valid", {31'd0, rsp_valid}, 32'd0);
    chk("bp_after_hs_ready", {31'd0, cmd_ready}, 32'd1);
    chk("bp_not_yet_accepted", {31'd0, cyc}, 32'd0);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("bp_accepted_cyc", {31'd0, cyc}, 32'd1);
    chk("bp_accepted_adr", adr, 32'h3000_0010);
    chk("bp_accepted_sel", {28'd0, sel}, 32'hC);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("bp_wr_rsp_dat", rsp_dat, 32'h0);
    rsp_handshake();

    // Asynchronous reset in the third bus-wait cycle
    issue(1'b0, 32'h3000_0014, 32'h0, 4'hF);
    @(negedge clk);
    @(negedge clk);
    chk("ar_cyc_before", {31'd0, cyc}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_cyc", {31'd0, cyc}, 32'd0);
    chk("ar_stb", {31'd0, stb}, 32'd0);
    chk("ar_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("ar_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ar_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("ar_no_rsp", {31'd0, rsp_valid}, 32'd0);
    issue(1'b0, 32'h3000_0018, 32'h0, 4'hF);
    chk("ar_rd_adr", adr, 32'h3000_0018);
    ack   = 1'b1;
    dat_i = 32'h8765_4321;
    @(negedge clk);
    ack = 1'b0;
    chk("ar_rd_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("ar_rd_rsp_dat", rsp_dat, 32'h8765_4321);
    chk("ar_rd_rsp_err", {31'd0, rsp_err}, 32'd0);
    rsp_handshake();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
